// File: rtl/bcd2bin_pkg.sv
// Shared constants for the BCD <-> binary conversion path: digit width,
// the largest legal BCD digit and the converter FSM encoding.
package bcd2bin_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CONV = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic logic isBadDigit(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// start/din request side and ertek/ready/hiba/tulcsordulas/busy result side
// of the BCD-to-binary converter, same handshake as the divider.
interface bcd2bin_if
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BITS   = 8
) ();

  logic                      i_start;
  logic [DIGIT_W*DIGITS-1:0] i_din;
  logic [BITS-1:0]           o_ertek;
  logic                      o_ready;
  logic                      o_hiba;
  logic                      o_tulcsordulas;
  logic                      o_busy;

  modport master (
    output i_start, i_din,
    input  o_ertek, o_ready, o_hiba, o_tulcsordulas, o_busy
  );

  modport slave (
    input  i_start, i_din,
    output o_ertek, o_ready, o_hiba, o_tulcsordulas, o_busy
  );

endinterface

// File: rtl/bcd2bin_mul10_add.sv
// Combinational acc*10 + digit via shift-add; the sum is BITS+4 wide so the
// caller can detect overflow past BITS bits.
module bcd2bin_mul10_add
  import bcd2bin_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0]         i_acc,
  input  logic [DIGIT_W-1:0]      i_digit,
  output logic [BITS+DIGIT_W-1:0] o_sum
);

  logic [BITS+DIGIT_W-1:0] w_accExt;

  assign w_accExt = {{DIGIT_W{1'b0}}, i_acc};
  assign o_sum    = (w_accExt << 3) + (w_accExt << 1) + (BITS+DIGIT_W)'(i_digit);

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: one digit per clock, most significant
// digit first, acc = acc*10 + digit, with sticky invalid-digit/overflow flags.
module bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  bcd2bin_if.slave   bus
);

  localparam int W = DIGIT_W * DIGITS;

  state_t                  r_state;
  logic [W-1:0]            r_shift;
  logic [BITS-1:0]         r_acc;
  logic [2:0]              r_cnt;
  logic                    r_err;
  logic                    r_ovf;
  logic [BITS-1:0]         r_ertek;
  logic                    r_ready;
  logic                    r_hiba;
  logic                    r_tulcs;

  logic [DIGIT_W-1:0]      w_digit;
  logic [BITS+DIGIT_W-1:0] w_sum;
  logic                    w_errNext;
  logic                    w_ovfNext;

  assign w_digit   = r_shift[W-1 -: DIGIT_W];
  assign w_errNext = r_err | isBadDigit(w_digit);
  assign w_ovfNext = r_ovf | (|w_sum[BITS+DIGIT_W-1:BITS]);

  bcd2bin_mul10_add #(.BITS(BITS)) u_mul10 (
    .i_acc   (r_acc),
    .i_digit (w_digit),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_ertek <= '0;
      r_ready <= 1'b0;
      r_hiba  <= 1'b0;
      r_tulcs <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_shift <= bus.i_din;
            r_acc   <= '0;
            r_cnt   <= 3'(DIGITS);
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_shift <= r_shift << DIGIT_W;
          r_acc   <= w_sum[BITS-1:0];
          r_err   <= w_errNext;
          r_ovf   <= w_ovfNext;
          r_cnt   <= r_cnt - 3'd1;
          // Last digit: an invalid digit outranks overflow in the result.
          if (r_cnt == 3'd1) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
            if (w_errNext) begin
              r_ertek <= '0;
              r_hiba  <= 1'b1;
              r_tulcs <= 1'b0;
            end else if (w_ovfNext) begin
              r_ertek <= {BITS{1'b1}};
              r_hiba  <= 1'b0;
              r_tulcs <= 1'b1;
            end else begin
              r_ertek <= w_sum[BITS-1:0];
              r_hiba  <= 1'b0;
              r_tulcs <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ertek        = r_ertek;
  assign bus.o_ready        = r_ready;
  assign bus.o_hiba         = r_hiba;
  assign bus.o_tulcsordulas = r_tulcs;
  assign bus.o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_bcd2bin.sv
// Directed bench for bcd2bin (DIGITS=3, BITS=8): hand-computed results,
// latency, held outputs, back-to-back starts and reset abort.
module tb_bcd2bin;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] prevErtek;

  bcd2bin_if #(.DIGITS(3), .BITS(8)) bus ();

  bcd2bin #(.DIGITS(3), .BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then wait (bounded) for ready and check result and timing.
  task automatic applyStimulus(input logic [11:0] d, input logic [7:0] expE,
                               input logic expH, input logic expT, input string tag);
    int  n;
    bit  seen;
    bus.i_din   = d;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    checkOutput({tag, "/busy"}, 32'(bus.o_busy), 32'd1);
    n    = 0;
    seen = 0;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (bus.o_ready) seen = 1;
      else checkOutput({tag, "/held"}, 32'(bus.o_ertek), 32'(prevErtek));
    end
    checkOutput({tag, "/latency"}, 32'(n), 32'd3);
    checkOutput({tag, "/ertek"}, 32'(bus.o_ertek), 32'(expE));
    checkOutput({tag, "/hiba"}, 32'(bus.o_hiba), 32'(expH));
    checkOutput({tag, "/tulcs"}, 32'(bus.o_tulcsordulas), 32'(expT));
    prevErtek = expE;
    tick();
    checkOutput({tag, "/readyLow"}, 32'(bus.o_ready), 32'd0);
    checkOutput({tag, "/idle"}, 32'(bus.o_busy), 32'd0);
    checkOutput({tag, "/ertekHold"}, 32'(bus.o_ertek), 32'(expE));
  endtask

  initial begin
    logic expReady;
    clk         = 1'b0;
    rst         = 1'b1;
    checks      = 0;
    errors      = 0;
    prevErtek   = 8'd0;
    bus.i_start = 1'b0;
    bus.i_din   = '0;

    tick();
    tick();
    checkOutput("reset/ready", 32'(bus.o_ready), 32'd0);
    checkOutput("reset/busy", 32'(bus.o_busy), 32'd0);
    checkOutput("reset/ertek", 32'(bus.o_ertek), 32'd0);
    checkOutput("reset/hiba", 32'(bus.o_hiba), 32'd0);
    checkOutput("reset/tulcs", 32'(bus.o_tulcsordulas), 32'd0);
    rst = 1'b0;
    tick();

    applyStimulus(12'h255, 8'd255, 1'b0, 1'b0, "d255");
    applyStimulus(12'h256, 8'hFF,  1'b0, 1'b1, "d256");
    applyStimulus(12'h999, 8'hFF,  1'b0, 1'b1, "d999");
    applyStimulus(12'h1A3, 8'h00,  1'b1, 1'b0, "d1A3");
    applyStimulus(12'hF99, 8'h00,  1'b1, 1'b0, "dF99");
    applyStimulus(12'h000, 8'h00,  1'b0, 1'b0, "d000");
    applyStimulus(12'h042, 8'd42,  1'b0, 1'b0, "d042");

    // start held high: ready on cycles 4, 9, 14; din glitch during CONV ignored
    bus.i_din   = 12'h017;
    bus.i_start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 2) bus.i_din = 12'h200;
      if (c == 3) bus.i_din = 12'h017;
      expReady = (c == 4) || (c == 9) || (c == 14);
      checkOutput($sformatf("hold/ready%0d", c), 32'(bus.o_ready), 32'(expReady));
      if (expReady) checkOutput($sformatf("hold/ertek%0d", c), 32'(bus.o_ertek), 32'd17);
    end
    bus.i_start = 1'b0;
    prevErtek   = 8'd17;
    tick();
    checkOutput("hold/stopped", 32'(bus.o_busy), 32'd0);

    // reset in the middle of a conversion aborts it
    bus.i_din   = 12'h123;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    checkOutput("abort/busyBefore", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort/busy", 32'(bus.o_busy), 32'd0);
    checkOutput("abort/ready", 32'(bus.o_ready), 32'd0);
    checkOutput("abort/ertek", 32'(bus.o_ertek), 32'd0);
    checkOutput("abort/hiba", 32'(bus.o_hiba), 32'd0);
    checkOutput("abort/tulcs", 32'(bus.o_tulcsordulas), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("abort/noReady", 32'(bus.o_ready), 32'd0);
    end
    prevErtek = 8'd0;
    applyStimulus(12'h123, 8'd123, 1'b0, 1'b0, "d123");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
Name: bcd2bin

Overview:
- Sequential BCD-to-binary converter: reverse of the divider-based binary-to-BCD path feeding the seven-segment display.
- Converts a packed multi-digit BCD operand, entered digit-wise on switches or display digits, into a BITS-wide binary value for the calculator datapath.
- Uses the same start/ready/hiba handshake as the divider, so it drops into existing start chains.
- Multiply-accumulate, one digit per clock: acc = acc*10 + digit.

Parameters:
- DIGITS, 3, number of BCD digits in din (1..4).
- BITS, 8, width of the binary result.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin conversion; sampled only in IDLE.
- din, input, 4*DIGITS, packed BCD; most significant digit in din[4*DIGITS-1 -: 4].
- ertek, output, BITS, binary result; registered, held until the next ready.
- ready, output, 1, one-cycle pulse when ertek/hiba/tulcsordulas are valid.
- hiba, output, 1, a digit > 9 was present; held with ertek.
- tulcsordulas, output, 1, value ≥ 2^BITS; held with ertek.
- busy, output, 1, high in CONV and DONE.

Behaviour:
- Reset: one clk edge with rst=1 sets state IDLE; ertek=0, ready=0, hiba=0, tulcsordulas=0, busy=0; internal shift register, accumulator, counter and sticky flags cleared. Reset in any state aborts the conversion with no ready pulse.
- IDLE:
  - On edge with start=1: latch din into shift register, acc=0, cnt=DIGITS, clear sticky err/ovf, go CONV.
  - start=0: stay.
- CONV (one edge per digit):
  - d = top nibble of shift register; shift left by 4.
  - d > 9 sets sticky err.
  - next = (acc<<3)+(acc<<1)+d, computed in BITS+4 bits. Any nonzero bit above BITS-1 sets sticky ovf. acc keeps next[BITS-1:0].
  - cnt decrements; on the edge where cnt==1, go DONE and register outputs:
    - err: ertek=0, hiba=1, tulcsordulas=0 (hiba has priority).
    - else ovf: ertek={BITS{1}}, tulcsordulas=1, hiba=0.
    - else: ertek=acc result, hiba=0, tulcsordulas=0.
- DONE: ready=1 for exactly this cycle, then IDLE unconditionally.
- Latency and throughput:
  - start sampled at edge k → ready high after edge k+DIGITS, low after edge k+DIGITS+1.
  - Minimum start-to-start spacing is DIGITS+2 cycles.
- start in CONV or DONE is ignored; din changes after the latch edge have no effect.
- start held permanently high: back-to-back conversions, one ready every DIGITS+2 cycles.
- Outputs other than ready and busy change only on the DONE-entry edge.

Decomposition:
- Shared package:
  - State encoding IDLE/CONV/DONE (2-bit).
  - BCD_MAX=4'd9.
  - Any digit-width constant (4) shared with the display/BCD path.
- Natural sub-module: mul10_add, combinational acc*10+d via shift-add, parameterised by BITS, exposing the BITS+4 wide sum. It is reusable by the keypad-entry logic.

Test Plan (DIGITS=3, BITS=8):
- din=12'h255, one-cycle start → ready exactly 3 edges after the start edge; ertek=8'd255, hiba=0, tulcsordulas=0.
- din=12'h256 → ertek=8'hFF, tulcsordulas=1, hiba=0; din=12'h999 → same.
- din=12'h1A3 → ertek=0, hiba=1, tulcsordulas=0; din=12'hF99 (invalid and large) → hiba=1 only.
- din=12'h000 → ertek=0. Then din=12'h042 → ertek=8'd42; ertek stays 0 until that ready.
- start held high with din=12'h017 → ready pulses every 5 cycles, ertek=17. A start pulse mid-CONV with din=12'h200 is ignored (result still 17).
- rst asserted during CONV of 12'h123 → next cycle busy=0, all outputs 0, no ready. A following start with 12'h123 → ertek=8'd123.
